fetch_stage_param: RTL and testbench
====================================

Name: fetch_stage_param

Overview:
- Parametrised successor to the single-cycle instruction fetch block: an on-chip instruction memory plus a PC-driven fetch engine.
- Memory is loaded through a host write port while `working`=0. With `working`=1 the engine fetches one instruction per cycle and emits registered decoded fields to decode.
- New capabilities: configurable width and depth, stall, PC redirect, HALT and invalid-opcode detection, valid flag, PC output.

Parameters:
- ADDR_W, 9, instruction memory address width; DEPTH = 2^ADDR_W words.
- INSN_W, 32, instruction word width; must be ≥ 20.
- VALC_W, INSN_W-16, width of the valC field (low bits of the word).
- MAX_ICODE, 4'hB, highest legal icode; above this is invalid.

Ports:
- clock  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  host write address (used only when `working`=0).
- wEn  in  1  host write enable.
- wDat  in  INSN_W  host write data.
- working  in  1  1 = fetch engine runs, 0 = load/idle.
- stall  in  1  hold the current fetch output and PC.
- redirect  in  1  load PC from `redirect_pc` this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- icode  out  4  bits [INSN_W-1 : INSN_W-4].
- ifun  out  4  next 4 bits.
- rA  out  4  next 4 bits.
- rB  out  4  next 4 bits.
- valC  out  VALC_W  bits [VALC_W-1 : 0].
- fetch_pc  out  ADDR_W  address of the instruction on the outputs.
- fetch_valid  out  1  outputs hold a newly fetched instruction this cycle.
- halted  out  1  HALT (icode 0) fetched; engine stopped.
- insn_err  out  1  icode > MAX_ICODE fetched; engine stopped.

Behaviour:
- Reset (resetn=0, async):
  - pc=0, state=IDLE.
  - All outputs 0 (icode, ifun, rA, rB, valC, fetch_pc, fetch_valid, halted, insn_err).
  - Memory contents are not reset.
- States: IDLE, RUN, STOP.
- IDLE (`working`=0):
  - `wEn`=1 writes `wDat` to mem[addr] at the clock edge.
  - pc held at 0; fetch_valid=0; decoded outputs hold their last values.
  - `working`=1 sampled → RUN. The first fetch happens on the next edge.
- RUN, each edge:
  - `working`=0 → IDLE: pc←0, halted←0, insn_err←0, fetch_valid←0.
  - else if `redirect`=1: pc←redirect_pc, fetch_valid←0, outputs hold. Redirect has priority over stall and over fetch.
  - else if `stall`=1: pc, outputs and flags hold; fetch_valid←0.
  - else fetch: fields ← decode(mem[pc]), fetch_pc←pc, fetch_valid←1.
    - pc←pc+1, wrapping from DEPTH-1 to 0.
    - If fetched icode==0: halted←1, state→STOP, pc not incremented.
    - Else if icode>MAX_ICODE: insn_err←1, state→STOP, pc not incremented.
- Latency: outputs are registered; the instruction at pc appears one edge after the fetch edge.
- STOP:
  - fetch_valid←0; outputs, halted/insn_err and pc hold.
  - redirect and stall are ignored.
  - `working`=0 → IDLE (clears flags, pc←0).
- Writes while `working`=1 are ignored (memory unchanged), including in STOP.
- Memory read is combinational from the pc register; there is no read/write hazard because the modes are exclusive.
- Reset mid-RUN aborts immediately; memory is preserved, so a re-run after reset fetches the same program.

Test Plan:
- Load and run:
  - Stimulus: write 0:10f50008, 1:21450000, 2:20120000, 3:00000000, then `working`=1.
  - Required: consecutive valid cycles give (1,0,f,5,0008,pc0), (2,1,4,5,0000,pc1), (2,0,1,2,0000,pc2), (0,0,0,0,0000,pc3).
  - Then halted=1, fetch_valid=0, and pc stays at 3.
- Stall:
  - Stimulus: assert `stall` for 2 cycles after the pc0 fetch.
  - Required: outputs hold the pc0 values with fetch_valid=0 for 2 cycles; the next valid fetch is pc1.
- Redirect vs stall:
  - Stimulus: `redirect`=1, `redirect_pc`=2, `stall`=1 in the same cycle.
  - Required: fetch_valid=0 that cycle; the next valid fetch shows fetch_pc=2, icode=2, rA=1.
- Invalid opcode:
  - Stimulus: mem[0]=F0000000, run.
  - Required: insn_err=1, fetch_valid pulses once, then the engine stops. `working`=0 clears insn_err.
- Wrap:
  - Stimulus: ADDR_W=2; load 4 non-halt words and run.
  - Required: fetch_pc sequence 0,1,2,3,0,1.
- Async reset / write lockout:
  - Stimulus: drop resetn mid-RUN.
  - Required: all outputs are 0 immediately (before the next edge).
  - Stimulus: `wEn`=1 while `working`=1.
  - Required: the memory word is unchanged on re-fetch.

Source files
------------

// File: rtl/fetch_stage_param.sv
// Instruction memory plus PC-driven fetch engine; decoded fields are registered, one edge after the fetch edge.
// No backpressure out: stall holds pc/outputs, redirect reloads pc, HALT or an illegal icode park the engine until working drops.
module fetch_stage_param #(
    parameter int         ADDR_W    = 9,
    parameter int         INSN_W    = 32,
    parameter int         VALC_W    = INSN_W - 16,
    parameter logic [3:0] MAX_ICODE = 4'hB
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wEn,
    input  logic [INSN_W-1:0] wDat,
    input  logic              working,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [VALC_W-1:0] valC,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_valid,
    output logic              halted,
    output logic              insn_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [VALC_W-1:0] valc;
    } fields_t;

    logic [INSN_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    fields_t           fields_q, fields_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic [INSN_W-1:0] insn;
    fields_t           decoded;

    // Host port is only live while the engine is off, so the combinational
    // read below never races a write.
    always_ff @(posedge clock) begin
        if (wEn && !working) begin
            mem[addr] <= wDat;
        end
    end

    assign insn = mem[pc_q];

    always_comb begin
        decoded       = '0;
        decoded.icode = insn[INSN_W-1 -: 4];
        decoded.ifun  = insn[INSN_W-5 -: 4];
        decoded.ra    = insn[INSN_W-9 -: 4];
        decoded.rb    = insn[INSN_W-13 -: 4];
        decoded.valc  = insn[VALC_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fields_d   = fields_q;
        fetch_pc_d = fetch_pc_q;
        valid_d    = 1'b0;
        halted_d   = halted_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                pc_d     = '0;
                halted_d = 1'b0;
                err_d    = 1'b0;
                if (working) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!working) begin
                    state_d  = IDLE;
                    pc_d     = '0;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!stall) begin
                    fields_d   = decoded;
                    fetch_pc_d = pc_q;
                    valid_d    = 1'b1;
                    if (decoded.icode == 4'h0) begin
                        halted_d = 1'b1;
                        state_d  = STOP;
                    end else if (decoded.icode > MAX_ICODE) begin
                        err_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            STOP: begin
                if (!working) begin
                    state_d  = IDLE;
                    pc_d     = '0;
                    halted_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            fields_q   <= '0;
            fetch_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fields_q   <= fields_d;
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign icode       = fields_q.icode;
    assign ifun        = fields_q.ifun;
    assign rA          = fields_q.ra;
    assign rB          = fields_q.rb;
    assign valC        = fields_q.valc;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_valid = valid_q;
    assign halted      = halted_q;
    assign insn_err    = err_q;

endmodule

// File: tb/tb_fetch_stage_param.sv
// Directed bench for fetch_stage_param: a default-size instance plus a 4-word instance for pc wrap.
module tb_fetch_stage_param;

    logic        clock;
    logic        resetn;
    logic [8:0]  addr;
    logic        wEn;
    logic [31:0] wDat;
    logic        working;
    logic        stall;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [15:0] valC;
    logic [8:0]  fetch_pc;
    logic        fetch_valid, halted, insn_err;

    logic [1:0]  w_addr;
    logic        w_wEn;
    logic [31:0] w_wDat;
    logic        w_working;
    logic        w_stall;
    logic        w_redirect;
    logic [1:0]  w_redirect_pc;
    logic [3:0]  w_icode, w_ifun, w_rA, w_rB;
    logic [15:0] w_valC;
    logic [1:0]  w_fetch_pc;
    logic        w_fetch_valid, w_halted, w_insn_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_stage_param u_dut (
        .clock(clock), .resetn(resetn), .addr(addr), .wEn(wEn), .wDat(wDat),
        .working(working), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .halted(halted), .insn_err(insn_err)
    );

    fetch_stage_param #(.ADDR_W(2)) u_wrap (
        .clock(clock), .resetn(resetn), .addr(w_addr), .wEn(w_wEn), .wDat(w_wDat),
        .working(w_working), .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .icode(w_icode), .ifun(w_ifun), .rA(w_rA), .rB(w_rB), .valC(w_valC),
        .fetch_pc(w_fetch_pc), .fetch_valid(w_fetch_valid), .halted(w_halted), .insn_err(w_insn_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [8:0] a, input logic [31:0] d);
        addr = a;
        wDat = d;
        wEn  = 1'b1;
        tick();
        wEn  = 1'b0;
    endtask

    task automatic test_reset();
        logic [44:0] got;
        tick();
        tick();
        got = {icode, ifun, rA, rB, valC, fetch_pc, fetch_valid, halted, insn_err};
        total_cnt++;
        if (got !== 45'd0) $display("FAIL reset_outputs got=%h want=0", got);
        else pass_cnt++;
        resetn = 1'b1;
    endtask

    task automatic test_load_run();
        logic [41:0] exp_tab [4];
        logic [41:0] got;
        exp_tab[0] = {4'h1, 4'h0, 4'hf, 4'h5, 16'h0008, 9'd0, 1'b1};
        exp_tab[1] = {4'h2, 4'h1, 4'h4, 4'h5, 16'h0000, 9'd1, 1'b1};
        exp_tab[2] = {4'h2, 4'h0, 4'h1, 4'h2, 16'h0000, 9'd2, 1'b1};
        exp_tab[3] = {4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 9'd3, 1'b1};
        host_write(9'd0, 32'h10f50008);
        host_write(9'd1, 32'h21450000);
        host_write(9'd2, 32'h20120000);
        host_write(9'd3, 32'h00000000);
        working = 1'b1;
        tick();
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL run_first_edge fetch_valid=%b want=0", fetch_valid);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {icode, ifun, rA, rB, valC, fetch_pc, fetch_valid};
            total_cnt++;
            if (got !== exp_tab[i]) $display("FAIL run_fetch%0d got=%h want=%h", i, got, exp_tab[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (halted !== 1'b1) $display("FAIL halt_flag halted=%b want=1", halted);
        else pass_cnt++;
        redirect    = 1'b1;
        redirect_pc = 9'd1;
        tick();
        tick();
        redirect = 1'b0;
        got = {icode, ifun, rA, rB, valC, fetch_pc, fetch_valid};
        total_cnt++;
        if (got !== {4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 9'd3, 1'b0} || halted !== 1'b1)
            $display("FAIL stop_hold got=%h halted=%b want fetch_pc=3 valid=0 halted=1", got, halted);
        else pass_cnt++;
        working = 1'b0;
        tick();
        total_cnt++;
        if ({halted, fetch_valid} !== 2'b00) $display("FAIL idle_clear halted/valid=%b want=00", {halted, fetch_valid});
        else pass_cnt++;
    endtask

    task automatic test_stall();
        working = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({fetch_valid, fetch_pc, icode} !== {1'b1, 9'd0, 4'h1})
            $display("FAIL stall_pre valid=%b pc=%0d icode=%h want 1/0/1", fetch_valid, fetch_pc, icode);
        else pass_cnt++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if ({fetch_valid, fetch_pc, icode, rA, valC} !== {1'b0, 9'd0, 4'h1, 4'hf, 16'h0008})
                $display("FAIL stall_hold%0d valid=%b pc=%0d icode=%h rA=%h valC=%h want 0/0/1/f/0008",
                         i, fetch_valid, fetch_pc, icode, rA, valC);
            else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        total_cnt++;
        if ({fetch_valid, fetch_pc, icode, ifun} !== {1'b1, 9'd1, 4'h2, 4'h1})
            $display("FAIL stall_resume valid=%b pc=%0d icode=%h ifun=%h want 1/1/2/1", fetch_valid, fetch_pc, icode, ifun);
        else pass_cnt++;
        working = 1'b0;
        tick();
    endtask

    task automatic test_redirect();
        working = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 9'd2;
        stall       = 1'b1;
        tick();
        total_cnt++;
        if ({fetch_valid, fetch_pc} !== {1'b0, 9'd0})
            $display("FAIL redirect_cycle valid=%b pc=%0d want 0/0", fetch_valid, fetch_pc);
        else pass_cnt++;
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        total_cnt++;
        if ({fetch_valid, fetch_pc, icode, rA} !== {1'b1, 9'd2, 4'h2, 4'h1})
            $display("FAIL redirect_target valid=%b pc=%0d icode=%h rA=%h want 1/2/2/1", fetch_valid, fetch_pc, icode, rA);
        else pass_cnt++;
        working = 1'b0;
        tick();
    endtask

    task automatic test_invalid();
        host_write(9'd0, 32'hF0000000);
        working = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({fetch_valid, insn_err, icode, halted} !== {1'b1, 1'b1, 4'hF, 1'b0})
            $display("FAIL invalid_fetch valid=%b err=%b icode=%h halted=%b want 1/1/f/0", fetch_valid, insn_err, icode, halted);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({fetch_valid, insn_err, fetch_pc} !== {1'b0, 1'b1, 9'd0})
            $display("FAIL invalid_stop valid=%b err=%b pc=%0d want 0/1/0", fetch_valid, insn_err, fetch_pc);
        else pass_cnt++;
        working = 1'b0;
        tick();
        total_cnt++;
        if (insn_err !== 1'b0) $display("FAIL invalid_clear insn_err=%b want=0", insn_err);
        else pass_cnt++;
        host_write(9'd0, 32'h10f50008);
    endtask

    task automatic test_lockout_and_reset();
        logic [44:0] got;
        working = 1'b1;
        addr    = 9'd1;
        wDat    = 32'hFFFFFFFF;
        wEn     = 1'b1;
        tick();
        tick();
        tick();
        wEn = 1'b0;
        total_cnt++;
        if ({fetch_valid, fetch_pc, icode, ifun, rA, rB} !== {1'b1, 9'd1, 4'h2, 4'h1, 4'h4, 4'h5})
            $display("FAIL write_lockout valid=%b pc=%0d word=%h%h%h%h want 1/1/2145",
                     fetch_valid, fetch_pc, icode, ifun, rA, rB);
        else pass_cnt++;
        #2;
        resetn = 1'b0;
        #1;
        got = {icode, ifun, rA, rB, valC, fetch_pc, fetch_valid, halted, insn_err};
        total_cnt++;
        if (got !== 45'd0) $display("FAIL async_reset got=%h want=0", got);
        else pass_cnt++;
        working = 1'b0;
        tick();
        resetn = 1'b1;
        working = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({fetch_valid, fetch_pc, icode, valC} !== {1'b1, 9'd0, 4'h1, 16'h0008})
            $display("FAIL rerun_after_reset valid=%b pc=%0d icode=%h valC=%h want 1/0/1/0008", fetch_valid, fetch_pc, icode, valC);
        else pass_cnt++;
        working = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [1:0] exp_pc [6];
        exp_pc[0] = 2'd0; exp_pc[1] = 2'd1; exp_pc[2] = 2'd2;
        exp_pc[3] = 2'd3; exp_pc[4] = 2'd0; exp_pc[5] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            w_addr = 2'(i);
            w_wDat = {4'h3, 12'h000, 16'(i + 16'h00a0)};
            w_wEn  = 1'b1;
            tick();
        end
        w_wEn     = 1'b0;
        w_working = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            total_cnt++;
            if ({w_fetch_valid, w_fetch_pc, w_valC} !== {1'b1, exp_pc[i], 16'h00a0 + 16'(exp_pc[i])})
                $display("FAIL wrap%0d valid=%b pc=%0d valC=%h want 1/%0d/%h",
                         i, w_fetch_valid, w_fetch_pc, w_valC, exp_pc[i], 16'h00a0 + 16'(exp_pc[i]));
            else pass_cnt++;
        end
        w_working = 1'b0;
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        addr = '0; wEn = 1'b0; wDat = '0; working = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        w_addr = '0; w_wEn = 1'b0; w_wDat = '0; w_working = 1'b0;
        w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;

        test_reset();
        test_load_run();
        test_stall();
        test_redirect();
        test_invalid();
        test_lockout_and_reset();
        test_wrap();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
